// File: rtl/datapath_pkg.sv
// Shared types for the single-bus datapath: ALU opcodes, bus source offsets
// and the MUL/DIV sequencer state.
package datapath_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SHR  = 4'd4,
    ALU_SHRA = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_ROL  = 4'd8,
    ALU_NEG  = 4'd9,
    ALU_NOT  = 4'd10,
    ALU_MUL  = 4'd11,
    ALU_DIV  = 4'd12
  } alu_op_t;

  // Bus source offsets, counted after the NUM_REGS general registers.
  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZHI    = 2;
  localparam int SRC_ZLO    = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_MDR    = 5;
  localparam int SRC_INPORT = 6;
  localparam int SRC_C      = 7;
  localparam int SRC_FIXED  = 8;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/Register.sv
// Plain load-enabled register with asynchronous clear.
module Register #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide: shift-add and restoring division on
// operand magnitudes, sign fix-up folded into the final RUN cycle.
module mul_div_unit
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  alu_op_t                  op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic                     div_zero,
  output logic                     z_we,
  output logic        [DATA_W-1:0] z_hi,
  output logic        [DATA_W-1:0] z_lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  md_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, neg_q, neg_r, dz;
  logic [DATA_W-1:0]  acc, lo, mreg, dividend;
  logic [DATA_W-1:0]  acc_nxt, lo_nxt;
  logic [DATA_W:0]    sum, shifted, diff;
  logic [2*DATA_W-1:0] prod;
  logic               accept, last;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  assign accept = start && (op == ALU_MUL || op == ALU_DIV) &&
                  (state == MD_IDLE || state == MD_DONE);
  assign last   = (cnt == CNT_W'(DATA_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = MD_RUN;
      MD_RUN:  if (last)   state_nxt = MD_DONE;
      MD_DONE: state_nxt = accept ? MD_RUN : MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_RUN);
    done = (state == MD_DONE);
    z_we = (state == MD_RUN) && last;
  end

  // One iteration step: MUL shifts the partial product right, DIV shifts the
  // partial remainder left and trial-subtracts the divisor magnitude.
  always_comb begin
    sum     = {1'b0, acc} + (lo[0] ? {1'b0, mreg} : '0);
    shifted = {acc, lo[DATA_W-1]};
    diff    = shifted - {1'b0, mreg};
    if (is_div) begin
      acc_nxt = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
      lo_nxt  = {lo[DATA_W-2:0], ~diff[DATA_W]};
    end else begin
      acc_nxt = sum[DATA_W:1];
      lo_nxt  = {sum[0], lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      mreg     <= '0;
      dividend <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= (op == ALU_DIV);
      neg_q    <= a[DATA_W-1] ^ b[DATA_W-1];
      neg_r    <= a[DATA_W-1];
      dz       <= (op == ALU_DIV) && (b == '0);
      acc      <= '0;
      lo       <= (op == ALU_DIV) ? mag(a) : mag(b);
      mreg     <= (op == ALU_DIV) ? mag(b) : mag(a);
      dividend <= a;
      div_zero <= 1'b0;
    end else if (state == MD_RUN) begin
      if (last) begin
        div_zero <= dz;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc_nxt;
        lo  <= lo_nxt;
      end
    end
  end

  always_comb begin
    prod = {acc, lo};
    z_hi = '0;
    z_lo = '0;
    if (!is_div) begin
      {z_hi, z_lo} = neg_q ? -prod : prod;
    end else if (dz) begin
      z_hi = dividend;
      z_lo = '1;
    end else begin
      z_lo = neg_q ? -lo  : lo;
      z_hi = neg_r ? -acc : acc;
    end
  end

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: general registers, special registers, priority bus
// encoder, single-cycle ALU and the iterative MUL/DIV unit writing Z.
module param_bus_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [NUM_REGS-1:0] Rin,
  input  logic [NUM_REGS-1:0] Rout,
  input  logic                PCin,
  input  logic                PCout,
  input  logic                IRin,
  input  logic                Yin,
  input  logic                MARin,
  input  logic                MDRin,
  input  logic                MDRout,
  input  logic                HIin,
  input  logic                HIout,
  input  logic                LOin,
  input  logic                LOout,
  input  logic                Zin,
  input  logic                Zhighout,
  input  logic                Zlowout,
  input  logic                InPortout,
  input  logic                Cout,
  input  logic                Read,
  input  logic [DATA_W-1:0]   Mdatain,
  input  logic [DATA_W-1:0]   InPort,
  input  logic [DATA_W-1:0]   Cdata,
  input  alu_op_t             alu_op,
  input  logic                alu_start,
  output logic                alu_busy,
  output logic                alu_done,
  output logic                div_zero,
  output logic                bus_err,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   ir_out,
  output logic [DATA_W-1:0]   bus
);

  localparam int NSRC = NUM_REGS + SRC_FIXED;
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] r_q [NUM_REGS];
  logic [DATA_W-1:0] hi_q, lo_q, pc_q, ir_q, y_q, mar_q, mdr_q, zhi_q, zlo_q;
  logic [DATA_W-1:0] src_val [NSRC];
  logic [NSRC-1:0]   src_en;
  logic [DATA_W-1:0] bus_val, alu_res, md_hi, md_lo;
  logic              multi_drv, md_we;

  function automatic logic [DATA_W-1:0] alu_single(input alu_op_t op,
                                                   input logic [DATA_W-1:0] opa,
                                                   input logic [DATA_W-1:0] opb);
    logic [SH_W-1:0] s;
    s = opb[SH_W-1:0];
    case (op)
      ALU_ADD:  return opa + opb;
      ALU_SUB:  return opa - opb;
      ALU_AND:  return opa & opb;
      ALU_OR:   return opa | opb;
      ALU_SHR:  return opa >> s;
      ALU_SHRA: return $signed(opa) >>> s;
      ALU_SHL:  return opa << s;
      ALU_ROR:  return (opa >> s) | (opa << (DATA_W - int'(s)));
      ALU_ROL:  return (opa << s) | (opa >> (DATA_W - int'(s)));
      ALU_NEG:  return -opb;
      ALU_NOT:  return ~opb;
      default:  return '0;
    endcase
  endfunction

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_gpr
    Register #(.DATA_W(DATA_W)) u_r (
      .clk(Clock), .clr(Clear), .ld(Rin[g]), .d(bus_val), .q(r_q[g])
    );
  end

  Register #(.DATA_W(DATA_W)) u_hi  (.clk(Clock), .clr(Clear), .ld(HIin),  .d(bus_val), .q(hi_q));
  Register #(.DATA_W(DATA_W)) u_lo  (.clk(Clock), .clr(Clear), .ld(LOin),  .d(bus_val), .q(lo_q));
  Register #(.DATA_W(DATA_W)) u_pc  (.clk(Clock), .clr(Clear), .ld(PCin),  .d(bus_val), .q(pc_q));
  Register #(.DATA_W(DATA_W)) u_ir  (.clk(Clock), .clr(Clear), .ld(IRin),  .d(bus_val), .q(ir_q));
  Register #(.DATA_W(DATA_W)) u_y   (.clk(Clock), .clr(Clear), .ld(Yin),   .d(bus_val), .q(y_q));
  Register #(.DATA_W(DATA_W)) u_mar (.clk(Clock), .clr(Clear), .ld(MARin), .d(bus_val), .q(mar_q));
  Register #(.DATA_W(DATA_W)) u_mdr (.clk(Clock), .clr(Clear), .ld(MDRin),
                                     .d(Read ? Mdatain : bus_val), .q(mdr_q));

  assign src_en = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) src_val[i] = r_q[i];
    src_val[NUM_REGS + SRC_HI]     = hi_q;
    src_val[NUM_REGS + SRC_LO]     = lo_q;
    src_val[NUM_REGS + SRC_ZHI]    = zhi_q;
    src_val[NUM_REGS + SRC_ZLO]    = zlo_q;
    src_val[NUM_REGS + SRC_PC]     = pc_q;
    src_val[NUM_REGS + SRC_MDR]    = mdr_q;
    src_val[NUM_REGS + SRC_INPORT] = InPort;
    src_val[NUM_REGS + SRC_C]      = Cdata;
  end

  // Scan from the top down so the lowest-index asserted source wins.
  always_comb begin
    bus_val = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_en[i]) bus_val = src_val[i];
    end
  end

  assign multi_drv = |(src_en & (src_en - NSRC'(1)));

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)          bus_err <= 1'b0;
    else if (multi_drv) bus_err <= 1'b1;
  end

  assign alu_res = alu_single(alu_op, y_q, bus_val);

  mul_div_unit #(.DATA_W(DATA_W)) u_md (
    .clk      (Clock),
    .rst      (Clear),
    .start    (alu_start),
    .op       (alu_op),
    .a        ($signed(y_q)),
    .b        ($signed(bus_val)),
    .busy     (alu_busy),
    .done     (alu_done),
    .div_zero (div_zero),
    .z_we     (md_we),
    .z_hi     (md_hi),
    .z_lo     (md_lo)
  );

  // Z belongs to the MUL/DIV unit while it is busy.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      zhi_q <= '0;
      zlo_q <= '0;
    end else if (md_we) begin
      zhi_q <= md_hi;
      zlo_q <= md_lo;
    end else if (Zin && !alu_busy) begin
      zhi_q <= '0;
      zlo_q <= alu_res;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign ir_out    = ir_q;
  assign bus       = bus_val;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath: ALU vector table plus hand-written
// reset, conflict, MUL/DIV and memory-interface sequences.
module tb_param_bus_datapath;
  import datapath_pkg::*;

  logic        Clock, Clear;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, IRin, Yin, MARin, MDRin, MDRout, HIin, HIout, LOin, LOout;
  logic Zin, Zhighout, Zlowout, InPortout, Cout, Read, alu_start;
  logic [31:0] Mdatain, InPort, Cdata;
  alu_op_t     alu_op;
  logic        alu_busy, alu_done, div_zero, bus_err;
  logic [31:0] mem_addr, mem_wdata, ir_out, bus;

  int tests = 0;
  int fails = 0;

  typedef struct {
    alu_op_t     op;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  param_bus_datapath #(.DATA_W(32), .NUM_REGS(16)) dut (
    .Clock(Clock), .Clear(Clear), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .Zin(Zin), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .InPortout(InPortout), .Cout(Cout), .Read(Read),
    .Mdatain(Mdatain), .InPort(InPort), .Cdata(Cdata), .alu_op(alu_op),
    .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done),
    .div_zero(div_zero), .bus_err(bus_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .ir_out(ir_out), .bus(bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_ctl();
    Rin = '0; Rout = '0;
    PCin = 0; PCout = 0; IRin = 0; Yin = 0; MARin = 0; MDRin = 0; MDRout = 0;
    HIin = 0; HIout = 0; LOin = 0; LOout = 0; Zin = 0; Zhighout = 0; Zlowout = 0;
    InPortout = 0; Cout = 0; Read = 0; alu_start = 0;
  endtask

  task automatic load_y(input logic [31:0] v);
    clear_ctl(); InPort = v; InPortout = 1; Yin = 1; tick(); clear_ctl();
  endtask

  task automatic start_md(input alu_op_t op, input logic [31:0] bv);
    clear_ctl(); InPort = bv; InPortout = 1; alu_op = op; alu_start = 1; tick(); clear_ctl();
  endtask

  task automatic check_z(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
    clear_ctl(); Zhighout = 1; #1; check({nm, "_zhi"}, bus, ehi);
    Zhighout = 0; Zlowout = 1; #1; check({nm, "_zlo"}, bus, elo);
    clear_ctl();
  endtask

  task automatic wait_done(input int n0, output int n, output bit busy_ok);
    n = n0; busy_ok = 1;
    while (alu_done !== 1'b1 && n < 200) begin
      if (alu_busy !== 1'b1) busy_ok = 0;
      tick(); n++;
    end
  endtask

  initial begin
    int n;
    bit ok, seen;

    vecs[0]  = '{ALU_ADD,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C};
    vecs[1]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[2]  = '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    vecs[3]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[4]  = '{ALU_OR,   32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF};
    vecs[5]  = '{ALU_SHR,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[6]  = '{ALU_SHRA, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[7]  = '{ALU_SHL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    vecs[8]  = '{ALU_ROR,  32'h1234_5678, 32'h0000_0008, 32'h7812_3456};
    vecs[9]  = '{ALU_ROL,  32'h1234_5678, 32'h0000_0004, 32'h2345_6781};
    vecs[10] = '{ALU_NEG,  32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFB};
    vecs[11] = '{ALU_NOT,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[12] = '{ALU_SHR,  32'h0000_0010, 32'h0000_0021, 32'h0000_0008};
    vecs[13] = '{ALU_ROR,  32'hABCD_0123, 32'h0000_0000, 32'hABCD_0123};

    Clock = 0; Clear = 1; clear_ctl();
    InPort = '0; Mdatain = '0; Cdata = '0; alu_op = ALU_ADD;
    #3;
    check("rst_bus", bus, 32'h0);
    check("rst_busy_done_dz_err", {28'h0, alu_busy, alu_done, div_zero, bus_err}, 32'h0);
    check("rst_mem", mem_addr | mem_wdata | ir_out, 32'h0);
    repeat (2) @(posedge Clock);
    #3 Clear = 0;
    tick();

    // Register transfer through R3 into Y, Y observed via ADD with empty bus.
    InPort = 32'h1234_5678; InPortout = 1; Rin[3] = 1; tick(); clear_ctl();
    Rout[3] = 1; #1; check("r3_bus", bus, 32'h1234_5678);
    Yin = 1; tick(); clear_ctl();
    alu_op = ALU_ADD; Zin = 1; tick(); clear_ctl();
    Zlowout = 1; #1; check("y_value", bus, 32'h1234_5678); clear_ctl();
    check("no_err", {31'h0, bus_err}, 32'h0);

    // Bus conflict and sticky error, then asynchronous mid-cycle Clear.
    InPort = 5; InPortout = 1; Rin[1] = 1; tick(); clear_ctl();
    InPort = 9; InPortout = 1; Rin[2] = 1; MARin = 1; IRin = 1; MDRin = 1; tick(); clear_ctl();
    Rout[1] = 1; Rout[2] = 1; #1;
    check("conflict_bus", bus, 32'h5);
    check("err_before_edge", {31'h0, bus_err}, 32'h0);
    tick(); clear_ctl();
    check("err_set", {31'h0, bus_err}, 32'h1);
    repeat (3) tick();
    check("err_sticky", {31'h0, bus_err}, 32'h1);
    Rout[2] = 1;
    #2 Clear = 1;
    #1;
    check("aclr_bus", bus, 32'h0);
    check("aclr_err", {31'h0, bus_err}, 32'h0);
    check("aclr_mem", mem_addr | mem_wdata | ir_out, 32'h0);
    #2 Clear = 0; clear_ctl();
    tick();
    check("post_clr_bus", bus, 32'h0);

    // MUL -3 * 7 with a second start ignored while busy.
    load_y(32'hFFFF_FFFD);
    start_md(ALU_MUL, 32'h0000_0007);
    check("mul_busy", {31'h0, alu_busy}, 32'h1);
    InPort = 32'd100; InPortout = 1; alu_op = ALU_MUL; alu_start = 1;
    tick(); tick(); clear_ctl();
    wait_done(2, n, ok);
    check("mul_latency", n, 32'd33);
    check("mul_busy_span", {31'h0, ok}, 32'h1);
    check("mul_done_busy", {31'h0, alu_busy}, 32'h0);
    check_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    tick();
    check("mul_done_pulse", {31'h0, alu_done}, 32'h0);

    // Single-cycle op with alu_start does not launch the unit.
    InPortout = 1; alu_op = ALU_ADD; alu_start = 1; tick(); clear_ctl();
    check("single_start_ignored", {31'h0, alu_busy}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      load_y(vecs[i].y);
      InPort = vecs[i].b; InPortout = 1; alu_op = vecs[i].op; Zin = 1; tick();
      check_z($sformatf("vec%0d", i), 32'h0, vecs[i].exp);
    end

    // DIV -7 / 2, then back-to-back -7 / 3 started in the done cycle.
    load_y(32'hFFFF_FFF9);
    start_md(ALU_DIV, 32'h0000_0002);
    wait_done(0, n, ok);
    check("div_latency", n, 32'd33);
    check_z("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("div_dz_clear", {31'h0, div_zero}, 32'h0);
    start_md(ALU_DIV, 32'h0000_0003);
    check("b2b_busy", {31'h0, alu_busy}, 32'h1);
    wait_done(0, n, ok);
    check("b2b_latency", n, 32'd33);
    check("b2b_busy_span", {31'h0, ok}, 32'h1);
    check_z("div_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // DIV by zero.
    load_y(32'h0000_000A);
    start_md(ALU_DIV, 32'h0000_0000);
    wait_done(0, n, ok);
    check("dz_latency", n, 32'd33);
    check_z("dz", 32'h0000_000A, 32'hFFFF_FFFF);
    check("dz_flag", {31'h0, div_zero}, 32'h1);

    // Clear in the middle of a DIV run.
    start_md(ALU_DIV, 32'h0000_0003);
    check("dz_cleared_by_start", {31'h0, div_zero}, 32'h0);
    repeat (10) tick();
    #2 Clear = 1;
    #1;
    check("mid_clr_busy", {31'h0, alu_busy}, 32'h0);
    check_z("mid_clr", 32'h0, 32'h0);
    #2 Clear = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (alu_done === 1'b1) seen = 1;
    end
    check("mid_clr_no_done", {31'h0, seen}, 32'h0);
    load_y(32'h0000_0006);
    start_md(ALU_MUL, 32'hFFFF_FFFC);
    wait_done(0, n, ok);
    check("restart_latency", n, 32'd33);
    check_z("restart_mul", 32'hFFFF_FFFF, 32'hFFFF_FFE8);

    // Memory interface, IR, PC, HI and source priority among specials.
    Read = 1; Mdatain = 32'hCAFE_F00D; MDRin = 1; tick(); clear_ctl();
    check("mdr_read", mem_wdata, 32'hCAFE_F00D);
    MDRout = 1; #1; check("mdr_bus", bus, 32'hCAFE_F00D); clear_ctl();
    InPort = 32'h0BAD_BEEF; InPortout = 1; MDRin = 1; MARin = 1; IRin = 1; tick(); clear_ctl();
    check("mdr_from_bus", mem_wdata, 32'h0BAD_BEEF);
    check("mar", mem_addr, 32'h0BAD_BEEF);
    check("ir", ir_out, 32'h0BAD_BEEF);
    Cdata = 32'hFFFF_FF80; Cout = 1; PCin = 1; tick(); clear_ctl();
    PCout = 1; #1; check("pc_from_c", bus, 32'hFFFF_FF80); clear_ctl();
    InPort = 32'h0000_0042; InPortout = 1; HIin = 1; tick(); clear_ctl();
    HIout = 1; Cout = 1; #1; check("hi_over_c", bus, 32'h0000_0042); clear_ctl();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_bus_datapath.md
# param_bus_datapath

Parametrised single-bus CPU datapath: `NUM_REGS` general registers plus HI, LO, PC, IR, Y, MAR, MDR and a 2×`DATA_W` Z register share one `DATA_W` bus. An internal bus encoder drives the bus from one-hot out-enables. The ALU performs single-cycle logic/arithmetic ops and iterative multi-cycle signed MUL/DIV with a start/busy/done handshake. The block sits between the control unit, which drives all enables, and memory, which is reached through MAR/MDR.

## Interface
Parameters:
- `DATA_W`, 32, bus/register width (≥8, even).
- `NUM_REGS`, 16, general register count (2..32).

Ports:
- `Clock` in 1: single clock, rising edge.
- `Clear` in 1: asynchronous, active-high reset.
- `Rin` in `NUM_REGS`: per-register load enables.
- `Rout` in `NUM_REGS`: per-register bus out-enables.
- `PCin`, `PCout`, `IRin`, `Yin`, `MARin`, `MDRin`, `MDRout`, `HIin`, `HIout`, `LOin`, `LOout`, `Zin`, `Zhighout`, `Zlowout`, `InPortout`, `Cout` in 1 each: load/out enables.
- `Read` in 1: MDR source select; 1 = `Mdatain`, 0 = bus.
- `Mdatain` in `DATA_W`: memory read data.
- `InPort` in `DATA_W`: external input port value.
- `Cdata` in `DATA_W`: sign-extended immediate from the control unit.
- `alu_op` in 4: operation code (see package).
- `alu_start` in 1: launch MUL/DIV.
- `alu_busy` out 1, `alu_done` out 1 (one-cycle pulse), `div_zero` out 1.
- `bus_err` out 1: sticky flag for multiple drivers.
- `mem_addr` out `DATA_W`: MAR contents.
- `mem_wdata` out `DATA_W`: MDR contents.
- `ir_out` out `DATA_W`: IR contents.
- `bus` out `DATA_W`: current bus value, for debug.

## Operation
- **Reset values.** All registers, Z, `alu_busy`, `alu_done`, `div_zero` and `bus_err` reset to 0, so every output is 0.
- **Bus source priority**, lowest index first: R0..R(N-1), HI, LO, Zhigh, Zlow, PC, MDR, InPort, C.
  - Zero out-enables asserted: bus = 0.
  - More than one asserted: the highest-priority source drives the bus and `bus_err` sets. It stays set until `Clear`.
- **Load enables.** Registers load the bus on the clock edge when their `*in` is high. Several loads in the same cycle are legal.
- **MDR** loads `Read ? Mdatain : bus` on `MDRin`.
- **Single-cycle ALU ops** (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT):
  - Operand A = Y, operand B = bus.
  - On `Zin`: Z_LO = result and Z_HI = 0.
  - Shift/rotate amount is B[log2(DATA_W)-1:0].
  - ADD and SUB wrap modulo 2^DATA_W.
- **MUL/DIV** run in the `mul_div_unit` FSM (IDLE → RUN → DONE → IDLE).
  - `alu_start` is sampled in IDLE with op MUL or DIV. Y and the bus are captured as operands.
  - RUN lasts `DATA_W` cycles: shift-add for MUL, restoring division on magnitudes for DIV, then sign fix-up.
  - MUL writes the signed 2×`DATA_W` product to {Z_HI, Z_LO}.
  - DIV writes Z_LO = quotient truncated toward zero and Z_HI = remainder carrying the dividend's sign.
  - DIV by 0: Z_LO = all ones, Z_HI = dividend, `div_zero` = 1. `div_zero` is cleared by the next `alu_start`. Latency is unchanged.
- **Ignored requests.**
  - `alu_start` while busy is ignored.
  - `alu_start` with a single-cycle op is ignored.
  - `Zin` while busy is ignored, so Z is owned by the unit.
- **Reset mid-operation**: `Clear` during RUN returns the FSM to IDLE immediately. Z is cleared and no done pulse follows.

## Timing
- Register write: the new value is visible on the bus in the cycle after the load edge.
- Zero combinational latency from out-enables to `bus`.
- MUL/DIV, with `alu_start` sampled on edge k:
  - `alu_busy` = 1 on cycles k+1 .. k+`DATA_W`+1.
  - Z is written on edge k+`DATA_W`+1.
  - `alu_done` = 1 for exactly the cycle after that edge, while `alu_busy` = 0.
  - Latency is independent of the operand values.
- `alu_start` in the `alu_done` cycle is accepted, giving back-to-back operations.
- `bus_err` sets on the edge following the conflicting cycle.

## Structure
- Package `datapath_pkg` holds:
  - `alu_op_t` encodings: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, NEG=9, NOT=10, MUL=11, DIV=12.
  - Bus source index constants.
  - The FSM state typedef.
- Sub-module `mul_div_unit` (parametrised by `DATA_W`) contains the iterative MUL/DIV FSM.
- Plain registers reuse the existing `Register` module, instantiated with generate loops.

## Test plan
- **Reset.** Assert `Clear` asynchronously mid-cycle → all outputs are 0 immediately. Deassert, then drive `Rout`=0 → bus = 0.
- **Register transfer.** `InPort`=0x1234_5678, `InPortout`+`Rin[3]`, then `Rout[3]`+`Yin` → Y = 0x1234_5678 and `bus_err` = 0.
- **Bus conflict.** `Rout[1]` and `Rout[2]` asserted together, with R1=5 and R2=9 → bus = 5 and `bus_err` = 1, sticky until `Clear`.
- **MUL.** Y = -3 (0xFFFF_FFFD), bus = 7, MUL start → `alu_done` appears 33 cycles after the start edge, with Z_HI = 0xFFFF_FFFF and Z_LO = 0xFFFF_FFEB. A second `alu_start` during busy is ignored.
- **DIV.** -7 / 2 → Z_LO = 0xFFFF_FFFD, Z_HI = 0xFFFF_FFFF. 10 / 0 → Z_LO = 0xFFFF_FFFF, Z_HI = 10, `div_zero` = 1.
- **Clear mid-DIV and MDR source.**
  - `Clear` at RUN cycle 10 → no `alu_done`, Z = 0, and a new start works normally.
  - `Read`=1 with `Mdatain`=0xCAFE_F00D and `MDRin` → `mem_wdata` = 0xCAFE_F00D.
